ps2_keyboard_port: RTL
======================

// Module: ps2_keyboard_port
// PURPOSE
//  Input-side companion to the CPU-driven display: receives PS/2 keyboard scan codes and presents them to the
//  kcpsm3 through its INPUT port interface (port_id/read_strobe/in_port).
//  Frames are deserialized and checked, then buffered in a FIFO; the CPU pops bytes from a data port and polls a status port.
//  Sits beside the display and program memory in the top level; its in_port is muxed into cpuReadData.
// PARAMETERS
//  PORT_BASE        8'h01   data port = PORT_BASE, status port = PORT_BASE+1; bit 7 must be 0
//  FIFO_DEPTH_LOG2  4       FIFO holds 2**FIFO_DEPTH_LOG2 bytes
//  TIMEOUT_CYCLES   50000   clk cycles without a PS/2 falling edge mid-frame before the frame is aborted
// PORTS
//  clk          in   1  system clock; everything is sampled on its rising edge
//  reset        in   1  synchronous, active-high reset
//  ps2_clk      in   1  PS/2 clock pin, asynchronous
//  ps2_data     in   1  PS/2 data pin, asynchronous
//  port_id      in   8  kcpsm3 port_id
//  read_strobe  in   1  kcpsm3 read_strobe
//  in_port      out  8  read data to kcpsm3 (registered)
//  rx_ready     out  1  high while the FIFO is non-empty
// BEHAVIOUR
//  Reset: all of the following are cleared to 0:
//   - in_port, rx_ready
//   - FIFO pointers and count
//   - sticky flags
//   - frame state (IDLE), bit counter, timeout counter
//  Synchronization:
//   - ps2_clk and ps2_data each pass through a 2-flop synchronizer.
//   - A falling edge is sync'd clk at 1 in the previous cycle and 0 now.
//   - ps2_data is sampled in the cycle the falling edge is detected.
//  Frame FSM (runs on falling edges):
//   - IDLE -> DATA when a start bit of 0 is seen. A start bit of 1 is ignored and the FSM stays in IDLE.
//   - DATA: 8 bits, LSB first -> PARITY -> STOP -> IDLE.
//   - Accept the frame only if the parity is odd over data+parity and the stop bit is 1.
//   - An accepted frame pushes the byte in the cycle after the stop edge.
//   - Bad parity or a bad stop bit: discard the byte and set perr.
//   - Timeout: the counter resets on every falling edge and runs in every state except IDLE.
//     At TIMEOUT_CYCLES the FSM returns to IDLE, discards the partial frame and sets no flag.
//  FIFO:
//   - Push when a frame is accepted, pop on read_strobe with port_id==PORT_BASE.
//   - Pop while empty: no effect; in_port still returns the stale head value.
//   - Push while full with no pop in the same cycle: drop the byte and set ovf.
//   - Push and pop in the same cycle: both take effect, including when the FIFO is full; count is unchanged.
//   - Pointers wrap modulo depth; count is FIFO_DEPTH_LOG2+1 bits wide.
//  Port read (kcpsm3 holds port_id 2 cycles; read_strobe is in the 2nd cycle and in_port is captured at its end):
//   - in_port is registered every cycle from port_id, so it is valid in the 2nd cycle.
//   - port_id==PORT_BASE   -> FIFO head.
//   - port_id==PORT_BASE+1 -> {4'b0, perr, ovf, full, !empty}.
//   - Any other port_id -> 8'h00, so the top level can OR-combine in_port with other peripherals.
//   - read_strobe on the status port clears ovf and perr.
//   - An event that sets a flag in the same cycle as the clear wins: the flag stays 1.
//  rx_ready = !empty, registered with the FIFO state.
//  Reset mid-frame: the partial frame is lost, and the receiver resyncs on the next start bit.
// STRUCTURE
//  Shared package (ps2_pkg):
//   - status bit indices: ST_NEMPTY=0, ST_FULL=1, ST_OVF=2, ST_PERR=3
//   - data/status port offsets 0/1
//   - FSM state encoding: IDLE, DATA, PARITY, STOP
//  One sub-module: ps2_rx_frame (synchronizer, edge detect, FSM, timeout; outputs byte + valid + perr_pulse).
//  FIFO and port decode stay in this module.
// TESTING
//  1. Send frame 0x1C (odd parity bit 0, stop 1), then INPUT PORT_BASE
//     -> rx_ready=1 before the read; in_port=0x1C; rx_ready=0 after the read.
//  2. Send 0x1C with parity bit 1, then read status -> 8'h08; a second status read -> 8'h00; FIFO stays empty.
//  3. Send 17 bytes 0x00..0x10 with FIFO_DEPTH_LOG2=4
//     -> status 8'h07; data reads return 0x00..0x0F; the 0x10 byte is lost.
//  4. With the FIFO full, push and data-port read in the same cycle
//     -> count stays 16, the head is popped, the new byte is queued last, ovf=0.
//  5. Send start + 4 data bits, then idle > TIMEOUT_CYCLES, then a full frame 0x5A
//     -> only 0x5A is received and status shows no perr.
//  6. Assert reset mid-frame, then send frame 0xF0 -> in_port=0 while in reset; 0xF0 is received intact afterwards.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard port: status bit layout, port offsets,
// receive-frame state encoding and the frame parity rule.
package ps2_pkg;

    localparam int ST_NEMPTY = 0;
    localparam int ST_FULL   = 1;
    localparam int ST_OVF    = 2;
    localparam int ST_PERR   = 3;

    localparam logic [7:0] PORT_DATA_OFS   = 8'd0;
    localparam logic [7:0] PORT_STATUS_OFS = 8'd1;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } rxStateT;

    // PS/2 uses odd parity: data bits plus parity bit must hold an odd number of ones.
    function automatic logic parityOk(input logic [7:0] data, input logic parityBit);
        return ^{data, parityBit};
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: synchronizes the pins, detects PS/2 clock falling edges and
// deserializes start/8 data/parity/stop, aborting a stalled frame after a timeout.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2Clk,
    input  logic       ps2Data,
    output logic [7:0] rxByte,
    output logic       rxValid,
    output logic       perrPulse
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]    clkSync;
    logic [1:0]    dataSync;
    logic          clkPrev;
    logic          fallEdge;
    logic          bitIn;
    logic          timeoutHit;
    rxStateT       state;
    rxStateT       stateNext;
    logic [2:0]    bitCnt;
    logic [7:0]    shiftReg;
    logic          parityBit;
    logic [TW-1:0] timeoutCnt;

    // NOTE: sequential state uses non-blocking <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            clkSync  <= '0;
            dataSync <= '0;
            clkPrev  <= 1'b0;
        end else begin
            clkSync  <= {clkSync[0], ps2Clk};
            dataSync <= {dataSync[0], ps2Data};
            clkPrev  <= clkSync[1];
        end
    end

    assign fallEdge = clkPrev & ~clkSync[1];
    assign bitIn    = dataSync[1];
    assign rxByte   = shiftReg;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    // NOTE: every always_comb output gets a default first, so no path infers a latch.
    always_comb begin
        stateNext  = state;
        timeoutHit = (state != IDLE) && !fallEdge && (timeoutCnt == TW'(TIMEOUT_CYCLES - 1));
        if (timeoutHit) begin
            stateNext = IDLE;
        end else if (fallEdge) begin
            case (state)
                IDLE:    if (!bitIn) stateNext = DATA;
                DATA:    if (bitCnt == 3'd7) stateNext = PARITY;
                PARITY:  stateNext = STOP;
                STOP:    stateNext = IDLE;
                default: stateNext = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bitCnt     <= '0;
            shiftReg   <= '0;
            parityBit  <= 1'b0;
            timeoutCnt <= '0;
            rxValid    <= 1'b0;
            perrPulse  <= 1'b0;
        end else begin
            rxValid   <= 1'b0;
            perrPulse <= 1'b0;
            if (state == IDLE || fallEdge) timeoutCnt <= '0;
            else                           timeoutCnt <= timeoutCnt + TW'(1);
            if (fallEdge) begin
                case (state)
                    IDLE:   bitCnt <= '0;
                    DATA: begin
                        shiftReg <= {bitIn, shiftReg[7:1]};
                        bitCnt   <= bitCnt + 3'd1;
                    end
                    PARITY: parityBit <= bitIn;
                    STOP: begin
                        rxValid   <= parityOk(shiftReg, parityBit) && bitIn;
                        perrPulse <= !(parityOk(shiftReg, parityBit) && bitIn);
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/ps2_keyboard_port.sv
// kcpsm3 input-port peripheral: buffers received PS/2 scan codes in a FIFO and
// exposes a data port (pop) and a status port (flags, cleared on read).
module ps2_keyboard_port
    import ps2_pkg::*;
#(
    parameter logic [7:0] PORT_BASE       = 8'h01,
    parameter int         FIFO_DEPTH_LOG2 = 4,
    parameter int         TIMEOUT_CYCLES  = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic [7:0] port_id,
    input  logic       read_strobe,
    output logic [7:0] in_port,
    output logic       rx_ready
);

    localparam int         DEPTH       = 1 << FIFO_DEPTH_LOG2;
    localparam int         CW          = FIFO_DEPTH_LOG2 + 1;
    localparam logic [7:0] DATA_PORT   = PORT_BASE + PORT_DATA_OFS;
    localparam logic [7:0] STATUS_PORT = PORT_BASE + PORT_STATUS_OFS;

    logic [7:0]                 rxByte;
    logic                       rxValid;
    logic                       perrPulse;
    logic [7:0]                 fifoMem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wrPtr;
    logic [FIFO_DEPTH_LOG2-1:0] rdPtr;
    logic [CW-1:0]              count;
    logic [CW-1:0]              countNext;
    logic                       empty, full;
    logic                       doPush, doPop, dropByte, clearFlags;
    logic                       ovf, perr;
    logic [7:0]                 statusByte;
    logic [7:0]                 readMux;

    ps2_rx_frame #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk       (clk),
        .reset     (reset),
        .ps2Clk    (ps2_clk),
        .ps2Data   (ps2_data),
        .rxByte    (rxByte),
        .rxValid   (rxValid),
        .perrPulse (perrPulse)
    );

    assign empty      = (count == '0);
    assign full       = (count == CW'(DEPTH));
    assign doPop      = read_strobe && (port_id == DATA_PORT) && !empty;
    // A simultaneous pop frees a slot, so a full FIFO still accepts the byte.
    assign doPush     = rxValid && (!full || doPop);
    assign dropByte   = rxValid && full && !doPop;
    assign clearFlags = read_strobe && (port_id == STATUS_PORT);

    always_comb begin
        countNext = count;
        if (doPush && !doPop)      countNext = count + CW'(1);
        else if (doPop && !doPush) countNext = count - CW'(1);
    end

    always_comb begin
        statusByte            = '0;
        statusByte[ST_NEMPTY] = !empty;
        statusByte[ST_FULL]   = full;
        statusByte[ST_OVF]    = ovf;
        statusByte[ST_PERR]   = perr;
        readMux               = 8'h00;
        if (port_id == DATA_PORT)        readMux = fifoMem[rdPtr];
        else if (port_id == STATUS_PORT) readMux = statusByte;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            rx_ready <= 1'b0;
            ovf      <= 1'b0;
            perr     <= 1'b0;
            in_port  <= 8'h00;
        end else begin
            if (doPush) wrPtr <= wrPtr + FIFO_DEPTH_LOG2'(1);
            if (doPop)  rdPtr <= rdPtr + FIFO_DEPTH_LOG2'(1);
            count    <= countNext;
            rx_ready <= (countNext != '0);
            // Set beats clear when both happen in the same cycle.
            ovf      <= (ovf && !clearFlags) || dropByte;
            perr     <= (perr && !clearFlags) || perrPulse;
            in_port  <= readMux;
        end
    end

    // NOTE: FIFO storage is deliberately not reset; pointers and count alone define valid entries.
    always_ff @(posedge clk) begin
        if (doPush) fifoMem[wrPtr] <= rxByte;
    end

endmodule
